// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the column-serial AES SubBytes + ShiftRows stage.
//   AES_STATE_W    : width of one AES state (128 bits)
//   aes_fsm_e      : stage FSM encoding (IDLE, SUB, DONE)
//   byte_msb()     : (row, col) -> MSB bit index of that byte in a state word
//   shift_src_col(): ShiftRows source column for a destination (row, col)
// Byte k of a state lives at bits [127-8k -: 8], and column c holds bytes
// 4c..4c+3 with row r at byte 4c+r (FIPS-197 column-major order).
// ---------------------------------------------------------------------------
package aes_pkg;

   localparam int AES_STATE_W = 128;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SUB  = 2'd1,
      ST_DONE = 2'd2
   } aes_fsm_e;

   // Byte index k = 4*col + row; its MSB is 127 - 8k = 8*(15-k) + 7,
   // which is simply {~k, 3'b111}.
   function automatic logic [6:0] byte_msb(input logic [1:0] row,
                                           input logic [1:0] col);
      logic [3:0] k;
      k = {col, row};
      return {~k, 3'b111};
   endfunction

   // Forward ShiftRows rotates row r left by r, so destination column col
   // reads source column col+r; the inverse reads col-r. The 2-bit
   // arithmetic wraps modulo 4 on its own.
   function automatic logic [1:0] shift_src_col(input logic [1:0] col,
                                                input logic [1:0] row,
                                                input logic       inv);
      logic [1:0] fwd_col;
      logic [1:0] inv_col;
      fwd_col = col + row;
      inv_col = col - row;
      return inv ? inv_col : fwd_col;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox
// Combinational AES byte substitution.
//   inv : 1 selects the inverse S-box (port exists only with SUB_SHIFT_INV_EN)
//   a   : input byte
//   y   : substituted byte
// Configuration macro: SUB_SHIFT_INV_EN adds the inverse table and the inv
// select; without it only the forward table is built.
// ---------------------------------------------------------------------------
module aes_sbox (
`ifdef SUB_SHIFT_INV_EN
   input  logic       inv,
`endif
   input  logic [7:0] a,
   output logic [7:0] y
);

   // Ascending packed range so the first listed byte is entry 0x00.
   localparam logic [0:255][7:0] FWD_TBL = {
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

`ifdef SUB_SHIFT_INV_EN
   localparam logic [0:255][7:0] INV_TBL = {
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   always_comb begin
      y = inv ? INV_TBL[a] : FWD_TBL[a];
   end
`else
   always_comb begin
      y = FWD_TBL[a];
   end
`endif

endmodule

// File: rtl/aes_sub_shift.sv
// ---------------------------------------------------------------------------
// aes_sub_shift
// Column-serial AES SubBytes + ShiftRows. A captured 128-bit state is
// substituted one output column per cycle through four shared S-boxes; the
// finished result is held on out_state until the downstream stage takes it.
// Ports:
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   in_valid   : upstream state available
//   in_ready   : stage can accept a state (high only in IDLE)
//   in_state   : input state
//   inv        : 1 = InvSubBytes + InvShiftRows (only with SUB_SHIFT_INV_EN)
//   out_valid  : out_state holds a finished result (high only in DONE)
//   out_ready  : downstream accepts the result
//   out_state  : substituted and shifted state
//   dbg_state  : current FSM state, for observation only
// Configuration macro: SUB_SHIFT_INV_EN adds the inv port, mode_reg and the
// inverse S-box / right-rotation path; the default build is forward only.
// ---------------------------------------------------------------------------
module aes_sub_shift
   import aes_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AES_STATE_W-1:0] in_state,
`ifdef SUB_SHIFT_INV_EN
   input  logic                   inv,
`endif
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [AES_STATE_W-1:0] out_state,
   output aes_fsm_e               dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid and ready
   // are both 1. in_ready and out_valid come straight from the registered
   // FSM state, so neither depends combinationally on in_valid/out_ready.
   // Upstream must hold in_state while in_valid=1 and in_ready=0; out_state
   // is stable while out_valid=1 and out_ready=0.

   aes_fsm_e               state;
   logic [1:0]             col;
   logic [AES_STATE_W-1:0] src_reg;
   logic [AES_STATE_W-1:0] dst_reg;
   logic                   mode;

   logic [7:0] sbox_in  [4];
   logic [7:0] sbox_out [4];

`ifdef SUB_SHIFT_INV_EN
   logic mode_reg;
   assign mode = mode_reg;
`else
   assign mode = 1'b0;
`endif

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign out_state = dst_reg;
   assign dbg_state = state;

   // Gather the four source bytes that land in output column col.
   always_comb begin
      for (int r = 0; r < 4; r++) begin
         sbox_in[r] = src_reg[byte_msb(2'(r), shift_src_col(col, 2'(r), mode)) -: 8];
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      aes_sbox u_sbox (
`ifdef SUB_SHIFT_INV_EN
         .inv (mode_reg),
`endif
         .a   (sbox_in[g]),
         .y   (sbox_out[g])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         col     <= 2'd0;
         src_reg <= '0;
         dst_reg <= '0;
`ifdef SUB_SHIFT_INV_EN
         mode_reg <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  src_reg <= in_state;
`ifdef SUB_SHIFT_INV_EN
                  mode_reg <= inv;
`endif
                  col     <= 2'd0;
                  state   <= ST_SUB;
               end
            end
            ST_SUB: begin
               for (int r = 0; r < 4; r++) begin
                  dst_reg[byte_msb(2'(r), col) -: 8] <= sbox_out[r];
               end
               col <= col + 2'd1;
               if (col == 2'd3) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               // Accepting here is deliberately not allowed: dst_reg must
               // stay untouched until the result has left.
               if (out_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
